// File: rtl/spi_slave.sv
// SPI mode-0 slave with a small bus register file: one-byte TX holding register,
// one-byte RX register, W1C status flags and a level interrupt on received data.
module spi_slave (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        int_sig_o,
    input  logic        spi_sclk_i,
    input  logic        spi_cs_n_i,
    input  logic        spi_mosi_i,
    output logic        spi_miso_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    // [0] first sync flop, [1] second sync flop, [2] history flop for edge detect
    logic [2:0] sclk_sync;
    logic [2:0] cs_sync;
    logic [2:0] mosi_sync;

    logic       en;
    logic       rxie;
    logic       rx_valid;
    logic       tx_empty;
    logic       overrun;
    logic [7:0] txdata;
    logic [7:0] rxdata;
    logic [7:0] tx_sr;
    logic [7:0] rx_sr;
    logic [2:0] bit_cnt;
    logic       reload_pending;

    logic       sclk_rise;
    logic       sclk_fall;
    logic       cs_fall;
    logic       cs_rise;
    logic       mosi_bit;
    logic       enter;
    logic       leaving;
    logic       active;
    logic       load;
    logic [7:0] load_val;
    logic       wr_ctrl;
    logic       wr_status;
    logic       wr_tx;
    logic       unused_bits;

    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign cs_fall   = ~cs_sync[1] & cs_sync[2];
    assign cs_rise   = cs_sync[1] & ~cs_sync[2];
    assign mosi_bit  = mosi_sync[1];

    assign wr_ctrl   = we_i && (addr_i[3:0] == 4'h0);
    assign wr_status = we_i && (addr_i[3:0] == 4'h4);
    assign wr_tx     = we_i && (addr_i[3:0] == 4'h8);

    assign unused_bits = ^{addr_i[31:4], data_i[31:8], mosi_sync[2]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk_sync <= 3'b000;
            cs_sync   <= 3'b111;
            mosi_sync <= 3'b000;
        end else begin
            sclk_sync <= {sclk_sync[1:0], spi_sclk_i};
            cs_sync   <= {cs_sync[1:0], spi_cs_n_i};
            mosi_sync <= {mosi_sync[1:0], spi_mosi_i};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (en && cs_fall) state_next = SHIFT;
            SHIFT:   if (!en || cs_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign enter    = (state == IDLE) && (state_next == SHIFT);
    assign leaving  = (state == SHIFT) && (state_next == IDLE);
    assign active   = (state == SHIFT) && (state_next == SHIFT);
    assign load     = enter || (active && sclk_fall && reload_pending);
    assign load_val = tx_empty ? 8'h00 : txdata;

    // A TXDATA write in the same cycle as a load lands after it: the load
    // consumes the old byte and the new byte is left pending (TX_EMPTY=0).
    always_ff @(posedge clk) begin
        if (!rst) begin
            en             <= 1'b0;
            rxie           <= 1'b0;
            rx_valid       <= 1'b0;
            tx_empty       <= 1'b1;
            overrun        <= 1'b0;
            txdata         <= 8'h00;
            rxdata         <= 8'h00;
            tx_sr          <= 8'h00;
            rx_sr          <= 8'h00;
            bit_cnt        <= 3'd0;
            reload_pending <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en   <= data_i[0];
                rxie <= data_i[1];
            end
            if (wr_status) begin
                if (data_i[0]) rx_valid <= 1'b0;
                if (data_i[3]) overrun  <= 1'b0;
            end
            if (load) begin
                tx_sr    <= load_val;
                tx_empty <= 1'b1;
            end
            if (wr_tx) begin
                txdata   <= data_i[7:0];
                tx_empty <= 1'b0;
            end
            if (enter || leaving) begin
                bit_cnt        <= 3'd0;
                reload_pending <= 1'b0;
            end else if (active) begin
                if (sclk_rise) begin
                    rx_sr   <= {rx_sr[6:0], mosi_bit};
                    bit_cnt <= bit_cnt + 3'd1;
                    // Byte completion sets RX_VALID after any W1C above, so set wins.
                    if (bit_cnt == 3'd7) begin
                        rxdata         <= {rx_sr[6:0], mosi_bit};
                        rx_valid       <= 1'b1;
                        reload_pending <= 1'b1;
                        if (rx_valid) overrun <= 1'b1;
                    end
                end
                if (sclk_fall) begin
                    if (reload_pending) begin
                        reload_pending <= 1'b0;
                    end else begin
                        tx_sr <= {tx_sr[6:0], 1'b0};
                    end
                end
            end
        end
    end

    assign spi_miso_o = (state == SHIFT) ? tx_sr[7] : 1'b0;
    assign int_sig_o  = rxie & rx_valid;

    always_comb begin
        data_o = 32'd0;
        case (addr_i[3:0])
            4'h0:    data_o[1:0] = {rxie, en};
            4'h4:    data_o[3:0] = {overrun, (state == SHIFT), tx_empty, rx_valid};
            4'h8:    data_o[7:0] = txdata;
            4'hC:    data_o[7:0] = rxdata;
            default: data_o = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a byte-level behavioural model of the register file and
// SPI framing is compared against the DUT outputs on every falling clk edge.
module tb_spi_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        int_sig_o;
    logic        spi_sclk_i;
    logic        spi_cs_n_i;
    logic        spi_mosi_i;
    logic        spi_miso_o;

    spi_slave dut (
        .clk        (clk),
        .rst        (rst),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .data_o     (data_o),
        .int_sig_o  (int_sig_o),
        .spi_sclk_i (spi_sclk_i),
        .spi_cs_n_i (spi_cs_n_i),
        .spi_mosi_i (spi_mosi_i),
        .spi_miso_o (spi_miso_o)
    );

    always #5 clk = ~clk;

    localparam int EV_CS_FALL = 0;
    localparam int EV_CS_RISE = 1;
    localparam int EV_RISE    = 2;
    localparam int EV_FALL    = 3;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    // Behavioural model state
    logic       m_en, m_rxie, m_rxv, m_tx_empty, m_ovr, m_shift, m_pending, ev_set;
    logic [7:0] m_txdata, m_rxdata, m_tx_byte, m_rx_acc;
    int         m_tx_idx, m_rx_bits;

    bit          mosi_q[$];
    logic        miso_cap[$];
    logic [31:0] rise_pre, rise_post;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_en = 0; m_rxie = 0; m_rxv = 0; m_tx_empty = 1; m_ovr = 0;
        m_shift = 0; m_pending = 0; m_txdata = 0; m_rxdata = 0;
        m_tx_byte = 0; m_rx_acc = 0; m_tx_idx = 0; m_rx_bits = 0; ev_set = 0;
    endfunction

    function automatic void model_load();
        m_tx_byte  = m_tx_empty ? 8'h00 : m_txdata;
        m_tx_empty = 1'b1;
        m_tx_idx   = 0;
    endfunction

    function automatic void model_event(input int kind, input logic mosi_b);
        ev_set = 1'b0;
        case (kind)
            EV_CS_FALL: if (m_en && !m_shift) begin
                m_shift = 1; m_rx_bits = 0; m_pending = 0; model_load();
            end
            EV_CS_RISE: if (m_shift) begin
                m_shift = 0; m_rx_bits = 0; m_pending = 0;
            end
            EV_RISE: if (m_shift) begin
                m_rx_acc = {m_rx_acc[6:0], mosi_b};
                m_rx_bits++;
                if (m_rx_bits == 8) begin
                    if (m_rxv) m_ovr = 1'b1;
                    m_rxdata = m_rx_acc; m_rxv = 1'b1; ev_set = 1'b1;
                    m_pending = 1'b1; m_rx_bits = 0;
                end
            end
            EV_FALL: if (m_shift) begin
                if (m_pending) begin
                    model_load(); m_pending = 0;
                end else begin
                    m_tx_idx++;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
        case (a[3:0])
            4'h0: begin m_en = d[0]; m_rxie = d[1]; end
            4'h4: begin
                if (d[0]) m_rxv = 1'b0;
                if (d[3]) m_ovr = 1'b0;
            end
            4'h8: begin m_txdata = d[7:0]; m_tx_empty = 1'b0; end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        case (a[3:0])
            4'h0:    return {30'd0, m_rxie, m_en};
            4'h4:    return {28'd0, m_ovr, m_shift, m_tx_empty, m_rxv};
            4'h8:    return {24'd0, m_txdata};
            4'hC:    return {24'd0, m_rxdata};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic model_miso();
        if (m_shift && m_tx_idx < 8) return m_tx_byte[7 - m_tx_idx];
        return 1'b0;
    endfunction

    function automatic int rh();
        return int'($urandom_range(7, 4));
    endfunction

    function automatic logic [7:0] cap_byte(input int k);
        logic [7:0] b = 8'h00;
        for (int i = 0; i < 8; i++) b = {b[6:0], miso_cap[8*k+i]};
        return b;
    endfunction

    function automatic void push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) mosi_q.push_back(b[i]);
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            check("miso", {31'd0, spi_miso_o}, {31'd0, model_miso()});
            check("int_sig", {31'd0, int_sig_o}, {31'd0, m_rxie & m_rxv});
            check("data_o", data_o, model_read(addr_i));
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bit en_drop;
        @(negedge clk); #1;
        we_i = 1'b1; addr_i = a; data_i = d;
        en_drop = (a[3:0] == 4'h0) && !d[0] && m_shift;
        model_write(a, d);
        @(posedge clk); #1;
        we_i = 1'b0; addr_i = 32'h4; data_i = 32'd0;
        if (en_drop) begin
            @(posedge clk); #1;
            m_shift = 0; m_rx_bits = 0; m_pending = 0;
        end
    endtask

    task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk); #1;
        addr_i = a;
        @(negedge clk);
        check(name, data_o, exp);
        #1 addr_i = 32'h4;
    endtask

    // One pin transition; the model takes it two negedges later, matching the
    // sync + edge-detect pipeline, optionally with a bus write in that same cycle.
    task automatic pin_event(input int kind, input logic mosi_v, input int half,
                             input bit cw, input logic [31:0] cw_a, input logic [31:0] cw_d);
        @(negedge clk); #1;
        case (kind)
            EV_CS_FALL: begin spi_cs_n_i = 1'b0; spi_mosi_i = mosi_v; end
            EV_CS_RISE: spi_cs_n_i = 1'b1;
            EV_RISE:    begin miso_cap.push_back(spi_miso_o); spi_sclk_i = 1'b1; end
            default:    begin spi_sclk_i = 1'b0; spi_mosi_i = mosi_v; end
        endcase
        @(negedge clk);
        @(negedge clk);
        if (kind == EV_RISE) rise_pre = data_o;
        #1;
        model_event(kind, spi_mosi_i);
        if (cw) begin
            we_i = 1'b1; addr_i = cw_a; data_i = cw_d;
            model_write(cw_a, cw_d);
        end
        if (ev_set) m_rxv = 1'b1;
        @(posedge clk); #1;
        we_i = 1'b0; addr_i = 32'h4; data_i = 32'd0;
        @(negedge clk);
        if (kind == EV_RISE) rise_post = data_o;
        repeat (half - 4) @(negedge clk);
    endtask

    // Frame of nbits from mosi_q; event index: 0 = CS fall, 2i+1 / 2i+2 = rise / fall of bit i.
    task automatic spi_frame(input int nbits, input bit pre_en, input logic [31:0] pre_a,
                             input logic [31:0] pre_d, input int cw_ev,
                             input logic [31:0] cw_a, input logic [31:0] cw_d);
        int ev = 0;
        miso_cap.delete();
        pin_event(EV_CS_FALL, mosi_q[0], rh(), ev == cw_ev, cw_a, cw_d);
        ev++;
        if (pre_en) wr(pre_a, pre_d);
        for (int i = 0; i < nbits; i++) begin
            pin_event(EV_RISE, 1'b0, rh(), ev == cw_ev, cw_a, cw_d);
            ev++;
            pin_event(EV_FALL, (i + 1 < nbits) ? mosi_q[i+1] : 1'b0, rh(), ev == cw_ev, cw_a, cw_d);
            ev++;
        end
        pin_event(EV_CS_RISE, 1'b0, rh(), ev == cw_ev, cw_a, cw_d);
        mosi_q.delete();
    endtask

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; we_i = 1'b0; addr_i = 32'h4; data_i = 32'd0;
        spi_sclk_i = 1'b0; spi_cs_n_i = 1'b1; spi_mosi_i = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1 chk_on = 1'b1;
        rst = 1'b1;

        // Reset values
        rd_check("rst_ctrl", 32'h0, 32'h0);
        rd_check("rst_status", 32'h4, 32'h2);
        rd_check("rst_txdata", 32'h8, 32'h0);
        rd_check("rst_rxdata", 32'hC, 32'h0);
        check("rst_miso", {31'd0, spi_miso_o}, 32'h0);
        check("rst_int", {31'd0, int_sig_o}, 32'h0);

        // Basic byte exchange and RX_VALID latency
        wr(32'h0, 32'h1);
        wr(32'h8, 32'hA5);
        push_byte(8'h3C);
        spi_frame(8, 0, 0, 0, -1, 0, 0);
        check("b1_miso", {24'd0, cap_byte(0)}, 32'hA5);
        check("b1_rxv_pre", {31'd0, rise_pre[0]}, 32'h0);
        check("b1_rxv_post", {31'd0, rise_post[0]}, 32'h1);
        rd_check("b1_rxdata", 32'hC, 32'h3C);
        rd_check("b1_status", 32'h4, 32'h3);

        // Back-to-back bytes, TXDATA written after first load, overrun
        wr(32'h4, 32'h9);
        push_byte(8'h11); push_byte(8'h22);
        spi_frame(16, 1, 32'h8, 32'h5A, -1, 0, 0);
        check("b2_miso0", {24'd0, cap_byte(0)}, 32'h00);
        check("b2_miso1", {24'd0, cap_byte(1)}, 32'h5A);
        rd_check("b2_rxdata", 32'hC, 32'h22);
        rd_check("b2_status", 32'h4, 32'hB);

        // TX empty at CS assert
        wr(32'h4, 32'h9);
        push_byte(8'h96);
        spi_frame(8, 0, 0, 0, -1, 0, 0);
        check("empty_miso", {24'd0, cap_byte(0)}, 32'h00);
        rd_check("empty_rxdata", 32'hC, 32'h96);

        // Partial byte discarded, next byte intact
        wr(32'h4, 32'h9);
        push_byte(8'hFF);
        spi_frame(5, 0, 0, 0, -1, 0, 0);
        rd_check("part_status", 32'h4, 32'h2);
        push_byte(8'h81);
        spi_frame(8, 0, 0, 0, -1, 0, 0);
        rd_check("part_rxdata", 32'hC, 32'h81);
        rd_check("part_status2", 32'h4, 32'h3);

        // Interrupt and W1C clear
        wr(32'h0, 32'h3);
        wr(32'h4, 32'h9);
        push_byte(8'h5C);
        spi_frame(8, 0, 0, 0, -1, 0, 0);
        @(negedge clk);
        check("irq_set", {31'd0, int_sig_o}, 32'h1);
        wr(32'h4, 32'h1);
        @(negedge clk);
        check("irq_clr", {31'd0, int_sig_o}, 32'h0);
        wr(32'h0, 32'h1);

        // TXDATA write coincident with the CS-fall load
        wr(32'h4, 32'h9);
        wr(32'h8, 32'hC3);
        push_byte(8'h01); push_byte(8'h02);
        spi_frame(16, 0, 0, 0, 0, 32'h8, 32'h3E);
        check("coll_miso0", {24'd0, cap_byte(0)}, 32'hC3);
        check("coll_miso1", {24'd0, cap_byte(1)}, 32'h3E);
        rd_check("coll_txdata", 32'h8, 32'h3E);

        // W1C coincident with byte completion: set wins
        wr(32'h4, 32'h9);
        push_byte(8'h44);
        spi_frame(8, 0, 0, 0, 15, 32'h4, 32'h1);
        rd_check("w1c_status", 32'h4, 32'h3);
        rd_check("w1c_rxdata", 32'hC, 32'h44);

        // EN dropped mid-frame
        wr(32'h4, 32'h9);
        push_byte(8'hFF);
        spi_frame(8, 1, 32'h0, 32'h0, -1, 0, 0);
        rd_check("endis_status", 32'h4, 32'h2);
        rd_check("endis_rxdata", 32'hC, 32'h44);
        wr(32'h0, 32'h1);

        // Reset during bit 4
        wr(32'h8, 32'h5A);
        push_byte(8'hB7);
        miso_cap.delete();
        pin_event(EV_CS_FALL, mosi_q[0], 4, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            pin_event(EV_RISE, 1'b0, 4, 0, 0, 0);
            pin_event(EV_FALL, mosi_q[i+1], 4, 0, 0, 0);
        end
        pin_event(EV_RISE, 1'b0, 4, 0, 0, 0);
        mosi_q.delete();
        @(negedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("rrst_status", data_o, 32'h2);
        check("rrst_miso", {31'd0, spi_miso_o}, 32'h0);
        #1 spi_sclk_i = 1'b0; spi_cs_n_i = 1'b1; spi_mosi_i = 1'b0;
        rd_check("rrst_ctrl", 32'h0, 32'h0);
        rd_check("rrst_txdata", 32'h8, 32'h0);
        rd_check("rrst_rxdata", 32'hC, 32'h0);
        @(negedge clk); #1 rst = 1'b1;
        repeat (4) @(negedge clk);
        rd_check("rrst_rxdata2", 32'hC, 32'h0);

        // Randomized traffic checked by the model
        wr(32'h0, 32'h1);
        for (int it = 0; it < 30; it++) begin
            logic [3:0] offs[8];
            int nb;
            offs = '{4'h1, 4'h2, 4'h4, 4'h5, 4'h7, 4'hC, 4'hD, 4'hF};
            if ($urandom_range(2, 0) == 0) wr($urandom & 32'hFFFF_FFF0 | 32'h8, $urandom);
            if ($urandom_range(3, 0) == 0)
                wr(($urandom & 32'hFFFF_FFF0) | {28'd0, offs[$urandom_range(7, 0)]}, $urandom);
            if ($urandom_range(4, 0) == 0) wr(32'h0, {30'd0, 1'($urandom_range(1, 0)), 1'b1});
            nb = int'($urandom_range(24, 1));
            for (int k = 0; k < nb; k++) mosi_q.push_back(1'($urandom_range(1, 0)));
            spi_frame(nb, $urandom_range(3, 0) == 0, 32'h8, $urandom, -1, 0, 0);
            @(negedge clk); #1 addr_i = $urandom;
            repeat (2) @(negedge clk);
            #1 addr_i = 32'h4;
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
